// File: rtl/sap_pkg.sv
// SAP timing constants shared by the ring counter and its step-edge detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sap_pkg;

    localparam int T_STATES = 6;

    typedef logic [T_STATES-1:0] tstate_t;

    localparam tstate_t T1 = tstate_t'(6'b000001);
    localparam tstate_t T2 = tstate_t'(6'b000010);
    localparam tstate_t T3 = tstate_t'(6'b000100);
    localparam tstate_t T4 = tstate_t'(6'b001000);
    localparam tstate_t T5 = tstate_t'(6'b010000);
    localparam tstate_t T6 = tstate_t'(6'b100000);

    // T-state index of the last fetch step (T3).
    localparam int FETCH_LAST = 2;

endpackage

// File: rtl/step_edge.sv
// Rising-edge detector for the debounced manual STEP button.
// Latency: PULSE is combinational from D in the cycle D first reads high.
// Backpressure: none; a rise not consumed by the caller is simply lost.
module step_edge (
    input  logic CLK,
    input  logic CLR,
    input  logic D,
    output logic PULSE
);

    logic d_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            d_q <= 1'b0;
        end else begin
            d_q <= D;
        end
    end

    assign PULSE = D & ~d_q;

endmodule

// File: rtl/ring_counter.sv
// One-hot T-state ring (T1..TN) with halt, early end (NXT) and single-step; RING_ONEHOT_CHECK_EN adds self-repair + sticky ERR.
// Latency: one CLK edge from inputs to new T/T_IDX; FETCH is combinational from T_IDX.
// Backpressure: HLT or missing step edge holds the ring; a STEP edge seen while halted is dropped.
module ring_counter
    import sap_pkg::*;
#(
    parameter int N_STATES = T_STATES,
    parameter int IDX_W    = $clog2(N_STATES)
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                HLT,
    input  logic                NXT,
    input  logic                STEP_MODE,
    input  logic                STEP,
    output logic [N_STATES-1:0] T,
    output logic [IDX_W-1:0]    T_IDX,
    output logic                FETCH,
    output logic                WRAP,
    output logic                ERR
);

    localparam logic [N_STATES-1:0] T_FIRST = N_STATES'(1);

    logic [N_STATES-1:0] t_q;
    logic [N_STATES-1:0] t_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic                wrap_q;
    logic                wrap_d;
    logic                step_rise;
    logic                adv;
    logic                recover;

    step_edge u_step_edge (
        .CLK   (CLK),
        .CLR   (CLR),
        .D     (STEP),
        .PULSE (step_rise)
    );

    assign adv = ~HLT & (~STEP_MODE | step_rise);

`ifdef RING_ONEHOT_CHECK_EN
    logic err_q;

    // Ring must be one-hot and agree with the index; an out-of-range index shifts to zero and mismatches.
    assign recover = ~$onehot(t_q) | (t_q != (T_FIRST << idx_q));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            err_q <= 1'b0;
        end else if (recover) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign recover = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_comb begin
        t_d    = t_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (recover) begin
            t_d   = T_FIRST;
            idx_d = '0;
        end else if (adv) begin
            if (NXT || t_q[N_STATES-1]) begin
                t_d    = T_FIRST;
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                t_d   = {t_q[N_STATES-2:0], t_q[N_STATES-1]};
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            t_q    <= T_FIRST;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign T     = t_q;
    assign T_IDX = idx_q;
    assign WRAP  = wrap_q;
    assign FETCH = (idx_q <= IDX_W'(FETCH_LAST));

endmodule

// File: tb/tb_ring_counter.sv
// Directed vector bench for ring_counter: table of per-edge inputs and hand-computed T/T_IDX/WRAP.
// The self-repair sequence is compiled in only when RING_ONEHOT_CHECK_EN is defined.
module tb_ring_counter;

    logic       clk;
    logic       clr;
    logic       hlt;
    logic       nxt;
    logic       step_mode;
    logic       step;
    logic [5:0] t;
    logic [2:0] t_idx;
    logic       fetch;
    logic       wrap;
    logic       err;

    int checks;
    int failures;

    typedef struct {
        logic       clr;
        logic       hlt;
        logic       nxt;
        logic       sm;
        logic       step;
        logic [5:0] exp_t;
        logic [2:0] exp_idx;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    ring_counter dut (
        .CLK       (clk),
        .CLR       (clr),
        .HLT       (hlt),
        .NXT       (nxt),
        .STEP_MODE (step_mode),
        .STEP      (step),
        .T         (t),
        .T_IDX     (t_idx),
        .FETCH     (fetch),
        .WRAP      (wrap),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic c, logic h, logic n, logic m, logic s,
                                logic [5:0] et, logic [2:0] ei, logic ew);
        vec_t v;
        v.clr = c; v.hlt = h; v.nxt = n; v.sm = m; v.step = s;
        v.exp_t = et; v.exp_idx = ei; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr = 1'b1; hlt = 1'b0; nxt = 1'b0; step_mode = 1'b0; step = 1'b0;

        // reset, then free run through one wrap
        vecs.push_back(mk(1,0,0,0,0, 6'h01, 3'd0, 0));
        vecs.push_back(mk(1,0,0,0,0, 6'h01, 3'd0, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h04, 3'd2, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h08, 3'd3, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h10, 3'd4, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h20, 3'd5, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h01, 3'd0, 1));
        vecs.push_back(mk(0,0,0,0,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h04, 3'd2, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h08, 3'd3, 0));
        // halt at T4 for three edges, then release
        vecs.push_back(mk(0,1,0,0,0, 6'h08, 3'd3, 0));
        vecs.push_back(mk(0,1,0,0,0, 6'h08, 3'd3, 0));
        vecs.push_back(mk(0,1,0,0,0, 6'h08, 3'd3, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h10, 3'd4, 0));
        // CLR beats HLT and NXT at T5
        vecs.push_back(mk(1,1,1,0,0, 6'h01, 3'd0, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h04, 3'd2, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h08, 3'd3, 0));
        // NXT at T4, then NXT masked by HLT
        vecs.push_back(mk(0,0,1,0,0, 6'h01, 3'd0, 1));
        vecs.push_back(mk(0,0,0,0,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,1,1,0,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h04, 3'd2, 0));
        // NXT while already in T1 still pulses WRAP
        vecs.push_back(mk(1,0,0,0,0, 6'h01, 3'd0, 0));
        vecs.push_back(mk(0,0,1,0,0, 6'h01, 3'd0, 1));
        vecs.push_back(mk(0,0,0,0,0, 6'h02, 3'd1, 0));
        // single step: held high advances once, second press advances again
        vecs.push_back(mk(1,0,0,0,0, 6'h01, 3'd0, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h04, 3'd2, 0));
        vecs.push_back(mk(0,0,0,1,0, 6'h04, 3'd2, 0));
        // NXT with a step edge wraps; NXT without one is ignored
        vecs.push_back(mk(0,0,1,1,1, 6'h01, 3'd0, 1));
        vecs.push_back(mk(0,0,1,1,0, 6'h01, 3'd0, 0));
        // leaving step mode runs freely from the preserved position
        vecs.push_back(mk(0,0,0,0,0, 6'h02, 3'd1, 0));
        // step edge during HLT is lost; still-high STEP does not re-trigger
        vecs.push_back(mk(0,1,0,1,1, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,0, 6'h02, 3'd1, 0));
        vecs.push_back(mk(0,0,0,1,1, 6'h04, 3'd2, 0));
        vecs.push_back(mk(0,0,0,0,0, 6'h08, 3'd3, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            clr = vecs[i].clr; hlt = vecs[i].hlt; nxt = vecs[i].nxt;
            step_mode = vecs[i].sm; step = vecs[i].step;
            tick();
            check($sformatf("v%0d T", i), int'(t), int'(vecs[i].exp_t));
            check($sformatf("v%0d T_IDX", i), int'(t_idx), int'(vecs[i].exp_idx));
            check($sformatf("v%0d WRAP", i), int'(wrap), int'(vecs[i].exp_wrap));
            check($sformatf("v%0d FETCH", i), int'(fetch),
                  int'(vecs[i].exp_t inside {6'h01, 6'h02, 6'h04}));
            check($sformatf("v%0d ERR", i), int'(err), 0);
        end

`ifdef RING_ONEHOT_CHECK_EN
        clr = 1'b0; hlt = 1'b0; nxt = 1'b0; step_mode = 1'b0; step = 1'b0;
        force dut.t_q = 6'b000110;
        tick();
        release dut.t_q;
        check("corrupt ERR", int'(err), 1);
        tick();
        check("recover T", int'(t), 6'h01);
        check("recover T_IDX", int'(t_idx), 0);
        check("recover ERR", int'(err), 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("sticky ERR %0d", k), int'(err), 1);
        end
        clr = 1'b1;
        tick();
        check("clear ERR", int'(err), 0);
        check("clear T", int'(t), 6'h01);
        clr = 1'b0;
        tick();
        check("post-clear T", int'(t), 6'h02);
        check("post-clear ERR", int'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
